alu_exec_pipe: RTL and testbench

Two-stage, valid/ready-handshaked execute unit that consumes the 3-bit `ALUctr` code produced by the ALU control decoder, together with two operands, and returns a registered result with zero/overflow/illegal flags. It sits between the decode stage, which drives `ALUctr`, `A` and `B`, and the writeback stage, which consumes the result. It sustains one operation per cycle under backpressure and keeps a completed-operation counter and a sticky overflow flag for lab debug.

---
 rtl/alu_exec_pipe.sv | 188 ++++++++++++++++++
 tb/tb_alu_exec_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pipe.sv
// ============================================================================
// Module   : alu_exec_pipe
// Purpose  : Two-stage valid/ready ALU execute unit with zero/overflow/illegal
//            flags, completed-operation counter and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [15:0]      op_count,
  output logic             ovf_seen
);

  localparam logic [2:0] OP_ADDU = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUBU = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;
  localparam int         MSB     = WIDTH - 1;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;

  // Stage 2 registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             overflow_q,  overflow_d;
  logic             illegal_q,   illegal_d;
  logic [15:0]      op_count_q,  op_count_d;
  logic             ovf_seen_q,  ovf_seen_d;

  // Handshake
  logic s1_adv;
  logic accept;
  logic out_hs;

  // ALU datapath
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             alu_illegal;

  always_comb begin
    s1_adv   = !out_valid_q || out_ready;
    in_ready = !reset && (!s1_valid_q || s1_adv);
    accept   = in_valid && in_ready;
    out_hs   = out_valid_q && out_ready;
  end

  // Unsigned borrow out of the subtract gives sltu for free.
  always_comb begin
    sum      = s1_a_q + s1_b_q;
    diff_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    diff     = diff_ext[WIDTH-1:0];
    borrow   = diff_ext[WIDTH];
    ovf_add  = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB]  != s1_a_q[MSB]);
    ovf_sub  = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
  end

  always_comb begin
    alu_result  = '0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (s1_op_q)
      OP_ADDU: alu_result = sum;
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = ovf_add;
      end
      OP_SUBU: alu_result = diff;
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = ovf_sub;
      end
      // Sign of the difference corrected by overflow keeps slt exact.
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, borrow};
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = ALUctr;
      s1_a_d     = A;
      s1_b_d     = B;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = alu_result;
        zero_d     = (alu_result == '0);
        overflow_d = alu_ovf;
        illegal_d  = alu_illegal;
      end
    end
  end

  always_comb begin
    op_count_d = op_count_q;
    ovf_seen_d = ovf_seen_q;
    if (out_hs) begin
      op_count_d = op_count_q + 16'd1;
      ovf_seen_d = ovf_seen_q || overflow_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 3'b000;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      op_count_q  <= 16'd0;
      ovf_seen_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      op_count_q  <= op_count_d;
      ovf_seen_q  <= ovf_seen_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    result    = result_q;
    zero      = zero_q;
    overflow  = overflow_q;
    illegal   = illegal_q;
    op_count  = op_count_q;
    ovf_seen  = ovf_seen_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_pipe.sv
// ============================================================================
// Module   : tb_alu_exec_pipe
// Purpose  : Directed scoreboard bench for alu_exec_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_pipe;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ovf;
    logic         ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   ALUctr;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         illegal;
  logic [15:0]  op_count;
  logic         ovf_seen;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_exec_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUctr(ALUctr), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal),
    .op_count(op_count), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: 33-bit signed arithmetic, overflow when the wide result
  // does not fit back into 32 bits.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W:0] wa, wb, wr;
    wa = {a[W-1], a};
    wb = {b[W-1], b};
    e  = '0;
    case (op)
      3'b000: e.res = a + b;
      3'b001: begin wr = wa + wb; e.res = wr[W-1:0]; e.ovf = (wr > 33'sh0_7FFF_FFFF) || (wr < -33'sh0_8000_0000); end
      3'b100: e.res = a - b;
      3'b101: begin wr = wa - wb; e.res = wr[W-1:0]; e.ovf = (wr > 33'sh0_7FFF_FFFF) || (wr < -33'sh0_8000_0000); end
      3'b111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110: e.res = (a < b) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Scoreboard checker: compares on every output handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",   result,   e.res);
        check("zero",     {31'd0, zero},     {31'd0, e.z});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("illegal",  {31'd0, illegal},  {31'd0, e.ill});
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_valid = 1'b1; ALUctr = op; A = a; B = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (in_ready) sb.push_back(model(op, a, b));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  logic [2:0]   bp_op [4];
  logic [W-1:0] bp_a  [4];
  logic [W-1:0] bp_b  [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; ALUctr = 3'b000; A = '0; B = '0; out_ready = 1'b0;
    bp_op[0] = 3'b001; bp_a[0] = 32'd10;         bp_b[0] = 32'd20;
    bp_op[1] = 3'b100; bp_a[1] = 32'd5;          bp_b[1] = 32'd7;
    bp_op[2] = 3'b111; bp_a[2] = 32'hFFFF_FFFF;  bp_b[2] = 32'd0;
    bp_op[3] = 3'b110; bp_a[3] = 32'hFFFF_FFFF;  bp_b[3] = 32'd0;

    // Reset state
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_flags",     {29'd0, zero, overflow, illegal}, 32'd0);
    check("rst_op_count",  {16'd0, op_count},  32'd0);
    check("rst_ovf_seen",  {31'd0, ovf_seen},  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Signed add overflow with 2-edge latency
    out_ready = 1'b1;
    send(3'b001, 32'h7FFF_FFFF, 32'd1);
    check("lat_k_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_k1_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_flag", {31'd0, overflow}, 32'd1);
    @(posedge clk); #1;
    check("ovf_seen_set", {31'd0, ovf_seen}, 32'd1);
    check("op_count_1", {16'd0, op_count}, 32'd1);

    // Back-to-back stream: wrap, compares, sub overflow, illegal
    send(3'b000, 32'hFFFF_FFFF, 32'd1);
    send(3'b111, 32'h8000_0000, 32'd1);
    send(3'b110, 32'h8000_0000, 32'd1);
    send(3'b101, 32'h8000_0000, 32'd1);
    send(3'b010, 32'h1234_5678, 32'h9);
    send(3'b011, 32'd0, 32'd0);
    drain();
    @(posedge clk); #1;
    check("op_count_7", {16'd0, op_count}, 32'd7);

    // Backpressure: two accepts then in_ready drops
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; ALUctr = bp_op[i]; A = bp_a[i]; B = bp_b[i];
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, (i < 2) ? 32'd1 : 32'd0);
      @(posedge clk);
      if (in_ready) sb.push_back(model(bp_op[i], bp_a[i], bp_b[i]));
      #1;
    end
    in_valid = 1'b0;
    check("bp_hold_result", result, 32'd30);
    check("bp_op_count_hold", {16'd0, op_count}, 32'd7);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    send(bp_op[2], bp_a[2], bp_b[2]);
    send(bp_op[3], bp_a[3], bp_b[3]);
    check("bp_stream_valid", {31'd0, out_valid}, 32'd1);
    drain();
    @(posedge clk); #1;
    check("op_count_11", {16'd0, op_count}, 32'd11);

    // Reset with both stages full
    out_ready = 1'b0;
    send(3'b000, 32'd1, 32'd2);
    send(3'b000, 32'd3, 32'd4);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_op_count", {16'd0, op_count}, 32'd0);
    check("midrst_ovf_seen", {31'd0, ovf_seen}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(3'b100, 32'd100, 32'd1);
    check("postrst_lat_k", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("postrst_lat_k1", {31'd0, out_valid}, 32'd1);
    check("postrst_result", result, 32'd99);
    drain();
    check("postrst_op_count", {16'd0, op_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
